// File: rtl/hist_eq_lut_if.sv
// Bus bundle for hist_eq_lut: cdf load handshake plus the streaming pixel path.
interface hist_eq_lut_if #(
  parameter int inWidth = 19
);
  logic               i_load_start;
  logic [inWidth-1:0] i_cdf;
  logic               i_cdf_valid;
  logic               o_cdf_ready;
  logic [7:0]         i_pixel;
  logic               i_pixel_valid;
  logic [7:0]         o_pixel;
  logic               o_pixel_valid;
  logic               o_load_done;
  logic               o_lut_valid;

  modport master (
    output i_load_start, i_cdf, i_cdf_valid, i_pixel, i_pixel_valid,
    input  o_cdf_ready, o_pixel, o_pixel_valid, o_load_done, o_lut_valid
  );

  modport slave (
    input  i_load_start, i_cdf, i_cdf_valid, i_pixel, i_pixel_valid,
    output o_cdf_ready, o_pixel, o_pixel_valid, o_load_done, o_lut_valid
  );
endinterface

// File: rtl/hist_eq_lut.sv
// Histogram-equalisation LUT: double-buffered 256x8 table loaded from a cdf stream,
// with a 2-cycle pixel mapping path that swaps tables cleanly between pixels.
module hist_eq_lut #(
  parameter int imageSize = 640*480,
  parameter int inWidth   = $clog2(imageSize)
) (
  input logic          i_clk,
  input logic          i_reset_n,
  hist_eq_lut_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  localparam int prodWidth = inWidth + 9;
  localparam logic [prodWidth-1:0] halfScale = prodWidth'(imageSize / 2);
  localparam logic [prodWidth-1:0] divisor   = prodWidth'(imageSize);

  state_t             state_q, state_d;
  logic [7:0]         level_q, level_d;
  logic               accept;
  logic               swap;

  logic               s1Valid_q;
  logic [inWidth-1:0] s1Cdf_q;
  logic [7:0]         s1Level_q;
  logic [prodWidth-1:0] quotient;
  logic [7:0]         scaled;

  logic               bankSel_q;
  logic               loadDone_q;
  logic               lutValid_q;
  logic [7:0]         lutMem [0:511];

  logic               p1Valid_q;
  logic               p1Bank_q;
  logic               p1Map_q;
  logic [7:0]         p1Pixel_q;
  logic               pixelValid_q;
  logic [7:0]         pixel_q;

  assign accept = bus.i_cdf_valid && (state_q == LOAD);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    swap    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_load_start) begin
          state_d = LOAD;
          level_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          level_d = level_q + 8'd1;
          if (level_q == 8'd255) state_d = FLUSH;
        end
      end
      FLUSH: begin
        // The level-255 write lands on this edge, so the table is complete.
        state_d = IDLE;
        swap    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  // Any cdf above imageSize yields a quotient of at least 255, so clamping covers saturation.
  always_comb begin
    quotient = (prodWidth'(s1Cdf_q) * prodWidth'(255) + halfScale) / divisor;
    scaled   = (|quotient[prodWidth-1:8]) ? 8'hFF : quotient[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      s1Valid_q  <= 1'b0;
      s1Cdf_q    <= '0;
      s1Level_q  <= '0;
      bankSel_q  <= 1'b0;
      loadDone_q <= 1'b0;
      lutValid_q <= 1'b0;
    end else begin
      s1Valid_q <= accept;
      if (accept) begin
        s1Cdf_q   <= bus.i_cdf;
        s1Level_q <= level_q;
      end
      bankSel_q  <= bankSel_q ^ swap;
      loadDone_q <= swap;
      lutValid_q <= lutValid_q | swap;
    end
  end

  always_ff @(posedge i_clk) begin
    if (s1Valid_q) lutMem[{~bankSel_q, s1Level_q}] <= scaled;
  end

  // Bank and identity choice travel with the pixel so a swap never splits a pixel.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      p1Valid_q    <= 1'b0;
      p1Bank_q     <= 1'b0;
      p1Map_q      <= 1'b0;
      p1Pixel_q    <= '0;
      pixelValid_q <= 1'b0;
      pixel_q      <= '0;
    end else begin
      p1Valid_q <= bus.i_pixel_valid;
      if (bus.i_pixel_valid) begin
        p1Pixel_q <= bus.i_pixel;
        p1Bank_q  <= bankSel_q;
        p1Map_q   <= lutValid_q;
      end
      pixelValid_q <= p1Valid_q;
      if (p1Valid_q) pixel_q <= p1Map_q ? lutMem[{p1Bank_q, p1Pixel_q}] : p1Pixel_q;
    end
  end

  assign bus.o_cdf_ready   = (state_q == LOAD);
  assign bus.o_pixel       = pixel_q;
  assign bus.o_pixel_valid = pixelValid_q;
  assign bus.o_load_done   = loadDone_q;
  assign bus.o_lut_valid   = lutValid_q;

endmodule

// File: tb/tb_hist_eq_lut.sv
// Directed bench for hist_eq_lut: pixel vector table plus hand-written load/swap/reset sequences.
module tb_hist_eq_lut;

  localparam int imageSize = 307200;
  localparam int inWidth   = 19;

  typedef struct {
    logic [7:0] pixel;
    logic [7:0] expected;
  } vec_t;

  logic i_clk = 1'b0;
  logic i_reset_n;
  vec_t vecs [16];
  int   vectorCount = 0;
  int   missCount   = 0;
  int   doneCount   = 0;

  always #5 i_clk = ~i_clk;

  hist_eq_lut_if #(.inWidth(inWidth)) bus ();

  hist_eq_lut #(.imageSize(imageSize), .inWidth(inWidth)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  always @(negedge i_clk) begin
    if (bus.o_load_done === 1'b1) doneCount++;
  end

  function automatic logic [inWidth-1:0] cdfOf(input int tbl, input int lvl);
    int v;
    v = 0;
    case (tbl)
      0: begin
        case (lvl)
          0: v = 0;
          1: v = 1205;
          2: v = 153600;
          3: v = 307200;
          4: v = 400000;
          default: v = 307200;
        endcase
      end
      1: v = lvl * 1200;
      default: v = (255 - lvl) * 1200;
    endcase
    return inWidth'(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectorCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx);
    @(negedge i_clk);
    bus.i_pixel       = vecs[idx].pixel;
    bus.i_pixel_valid = 1'b1;
    @(negedge i_clk);
    bus.i_pixel_valid = 1'b0;
    checkOutput($sformatf("latencyEarly%0d", idx), 32'(bus.o_pixel_valid), 32'd0);
    @(negedge i_clk);
    checkOutput($sformatf("pixelValid%0d", idx), 32'(bus.o_pixel_valid), 32'd1);
    checkOutput($sformatf("pixel%0d", idx), 32'(bus.o_pixel), 32'(vecs[idx].expected));
  endtask

  task automatic loadTable(input int tbl, input bit gaps, input int nXfer,
                           input logic [7:0] swapPix, input logic [7:0] oldExp,
                           input logic [7:0] newExp);
    int doneBefore;
    doneBefore = doneCount;
    @(negedge i_clk);
    bus.i_load_start  = 1'b1;
    bus.i_pixel       = swapPix;
    bus.i_pixel_valid = 1'b1;
    @(negedge i_clk);
    for (int lvl = 0; lvl < nXfer; lvl++) begin
      bus.i_load_start = 1'b0;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.i_cdf_valid = 1'b0;
          bus.i_cdf       = '1;
          @(negedge i_clk);
        end
      end
      bus.i_load_start = (lvl % 50 == 7);
      bus.i_cdf        = cdfOf(tbl, lvl);
      bus.i_cdf_valid  = 1'b1;
      #1;
      checkOutput($sformatf("cdfReady%0d", lvl), 32'(bus.o_cdf_ready), 32'd1);
      @(negedge i_clk);
    end
    bus.i_cdf_valid  = 1'b0;
    bus.i_load_start = 1'b0;
    if (nXfer == 256) begin
      checkOutput("flushReady", 32'(bus.o_cdf_ready), 32'd0);
      checkOutput("doneEarly", 32'(bus.o_load_done), 32'd0);
      checkOutput("preSwapPixel", 32'(bus.o_pixel), 32'(oldExp));
      @(negedge i_clk);
      checkOutput("loadDone", 32'(bus.o_load_done), 32'd1);
      checkOutput("lutValid", 32'(bus.o_lut_valid), 32'd1);
      checkOutput("idleReady", 32'(bus.o_cdf_ready), 32'd0);
      @(negedge i_clk);
      checkOutput("doneWidth", 32'(bus.o_load_done), 32'd0);
      checkOutput("swapEdgePixel", 32'(bus.o_pixel), 32'(oldExp));
      bus.i_pixel_valid = 1'b0;
      @(negedge i_clk);
      checkOutput("postSwapPixel", 32'(bus.o_pixel), 32'(newExp));
      @(negedge i_clk);
      checkOutput("pixelHold", 32'(bus.o_pixel), 32'(newExp));
      checkOutput("validLow", 32'(bus.o_pixel_valid), 32'd0);
      checkOutput("donePulses", 32'(doneCount - doneBefore), 32'd1);
    end else begin
      bus.i_pixel_valid = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneBefore;
    vecs[0]  = '{8'd0,   8'd0};
    vecs[1]  = '{8'd77,  8'd77};
    vecs[2]  = '{8'd255, 8'd255};
    vecs[3]  = '{8'd0,   8'd0};
    vecs[4]  = '{8'd1,   8'd1};
    vecs[5]  = '{8'd2,   8'd128};
    vecs[6]  = '{8'd3,   8'd255};
    vecs[7]  = '{8'd4,   8'd255};
    vecs[8]  = '{8'd200, 8'd255};
    vecs[9]  = '{8'd10,  8'd10};
    vecs[10] = '{8'd100, 8'd100};
    vecs[11] = '{8'd255, 8'd254};
    vecs[12] = '{8'd77,  8'd77};
    vecs[13] = '{8'd0,   8'd254};
    vecs[14] = '{8'd255, 8'd0};
    vecs[15] = '{8'd10,  8'd244};

    i_reset_n         = 1'b0;
    bus.i_load_start  = 1'b0;
    bus.i_cdf         = '0;
    bus.i_cdf_valid   = 1'b0;
    bus.i_pixel       = '0;
    bus.i_pixel_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    checkOutput("rstReady", 32'(bus.o_cdf_ready), 32'd0);
    checkOutput("rstPixelValid", 32'(bus.o_pixel_valid), 32'd0);
    checkOutput("rstDone", 32'(bus.o_load_done), 32'd0);
    checkOutput("rstLutValid", 32'(bus.o_lut_valid), 32'd0);
    checkOutput("rstPixel", 32'(bus.o_pixel), 32'd0);
    i_reset_n = 1'b1;

    for (int i = 0; i <= 2; i++) applyStimulus(i);
    checkOutput("lutValidIdle", 32'(bus.o_lut_valid), 32'd0);

    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      bus.i_cdf       = inWidth'(5);
      bus.i_cdf_valid = 1'b1;
      #1;
      checkOutput($sformatf("idleIgnore%0d", i), 32'(bus.o_cdf_ready), 32'd0);
    end
    bus.i_cdf_valid = 1'b0;

    loadTable(0, 1'b0, 256, 8'd3, 8'd3, 8'd255);
    for (int i = 3; i <= 8; i++) applyStimulus(i);

    loadTable(1, 1'b1, 256, 8'd10, 8'd255, 8'd10);
    for (int i = 9; i <= 11; i++) applyStimulus(i);

    doneBefore = doneCount;
    loadTable(2, 1'b1, 100, 8'd0, 8'd0, 8'd0);
    i_reset_n = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    checkOutput("abortReady", 32'(bus.o_cdf_ready), 32'd0);
    checkOutput("abortLutValid", 32'(bus.o_lut_valid), 32'd0);
    checkOutput("abortDone", 32'(bus.o_load_done), 32'd0);
    checkOutput("abortPixel", 32'(bus.o_pixel), 32'd0);
    repeat (4) @(negedge i_clk);
    checkOutput("abortNoPulse", 32'(doneCount - doneBefore), 32'd0);
    checkOutput("abortLutValidLater", 32'(bus.o_lut_valid), 32'd0);
    applyStimulus(12);

    loadTable(2, 1'b1, 256, 8'd10, 8'd10, 8'd244);
    for (int i = 13; i <= 15; i++) applyStimulus(i);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/hist_eq_lut.md
HIST_EQ_LUT -- requirements
Module: hist_eq_lut

Interface
REQ-001 Parameter imageSize, default 640*480: pixels per frame, and the divisor of the equalisation scale.
REQ-002 Parameter inWidth, default $clog2(imageSize): width of a cumulative-histogram value.
REQ-003 i_clk  input  1  clock; all logic is rising-edge.
REQ-004 i_reset_n  input  1  synchronous, active-low reset.
REQ-005 i_load_start  input  1  single-cycle pulse that starts a LUT load.
REQ-006 i_cdf  input  inWidth  cumulative count for the current level; levels arrive in order 0..255.
REQ-007 i_cdf_valid  input  1  i_cdf is valid this cycle.
REQ-008 o_cdf_ready  output  1  block accepts i_cdf; a transfer occurs when valid and ready are both high.
REQ-009 i_pixel  input  8  input pixel.
REQ-010 i_pixel_valid  input  1  i_pixel is valid this cycle.
REQ-011 o_pixel  output  8  equalised pixel.
REQ-012 o_pixel_valid  output  1  o_pixel is valid this cycle.
REQ-013 o_load_done  output  1  one-cycle pulse: the new table has become active.
REQ-014 o_lut_valid  output  1  at least one complete table has been loaded since reset.

Function
REQ-015 The block SHALL hold two 256x8 LUT banks: an active bank for mapping and a shadow bank for loading.
REQ-016 The FSM SHALL have three states: IDLE, LOAD and FLUSH.
  - IDLE -> LOAD on i_load_start.
  - LOAD -> FLUSH on the 256th accepted transfer.
  - FLUSH -> IDLE after the last shadow write completes.
REQ-017 o_cdf_ready SHALL be 1 only in LOAD; i_cdf_valid outside LOAD SHALL be ignored.
REQ-018 i_load_start SHALL be ignored in LOAD and FLUSH.
REQ-019 An 8-bit level counter SHALL:
  - clear on entry to LOAD;
  - increment per accepted transfer;
  - address the shadow write for that transfer.
REQ-020 Scaling SHALL be lut = floor((cdf*255 + imageSize/2) / imageSize).
  - Multiply at full width, with no intermediate truncation.
  - If cdf > imageSize, lut SHALL saturate to 255.
REQ-021 The cdf path SHALL be two register stages: stage 1 captures cdf and level; stage 2 writes the scaled value into the shadow bank.
REQ-022 In the cycle after the level-255 write (FLUSH exit), the block SHALL:
  - toggle the bank select;
  - pulse o_load_done for exactly one cycle;
  - set o_lut_valid to 1 (it then stays 1 until reset).
REQ-023 Pixel path latency SHALL be exactly 2 cycles; o_pixel_valid is i_pixel_valid delayed by 2 cycles.
  - The path has no backpressure, and a pixel is accepted every cycle.
REQ-024 Stage 1 of the pixel path SHALL register the pixel together with the bank select current at that edge.
  - A pixel sampled on the same edge as the bank toggle SHALL use the old bank.
  - Later pixels SHALL use the new bank.
REQ-025 While o_lut_valid=0, the pixel path SHALL map by identity (o_pixel = i_pixel), keeping the 2-cycle latency.
REQ-026 Pixel mapping SHALL continue, unaffected, during LOAD and FLUSH using the active bank.
REQ-027 When o_pixel_valid=0, o_pixel SHALL hold its last value.

Reset
REQ-028 On reset the block SHALL force the following, each taking effect at the next edge:
  - FSM to IDLE;
  - level counter, bank select and pipeline valid bits to 0;
  - o_cdf_ready, o_pixel_valid, o_load_done and o_lut_valid to 0;
  - o_pixel to 0.
REQ-029 Reset during LOAD or FLUSH SHALL abandon the load; no bank swap occurs and no o_load_done pulse is produced.
REQ-030 LUT bank contents need not be reset, because o_lut_valid=0 selects identity mapping.

Verification
REQ-031 Identity after reset: pixels 0, 77, 255 with no load -> o_pixel 0, 77, 255 two cycles later; o_lut_valid=0.
REQ-032 Scaling with imageSize=307200: cdf values 0, 1205, 153600, 307200, 400000 at levels 0..4 -> LUT entries 0, 1, 128, 255, 255.
  - Then feed pixels 0..4 -> o_pixel 0, 1, 128, 255, 255.
REQ-033 Full load with backpressure:
  - stimulus: 256 cdf values with i_cdf_valid deasserted for random gaps;
  - response: exactly one o_load_done pulse, following the 256th transfer; o_cdf_ready low in IDLE and FLUSH.
REQ-034 Swap boundary: continuous pixel stream during a second load -> the pixel sampled on the toggle edge uses the old table, and the next pixel uses the new table.
REQ-035 Reset mid-load after 100 transfers, then a full reload:
  - after the reset: no o_load_done, o_lut_valid=0, identity mapping;
  - after the reload: o_load_done pulses once and the new table is used.
REQ-036 Ignored inputs:
  - stimulus: i_load_start pulses during LOAD and i_cdf_valid asserted in IDLE;
  - response: level counter and FSM unaffected; exactly 256 writes per load.
